// File: rtl/branch_target_queue.sv
// FIFO of predicted branch targets/fallthroughs pushed at fetch and popped at resolve.
// Optional overflow drop counter enabled by defining BTQ_DROP_CNT_EN.
module branch_target_queue #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned IMM_W  = 21
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     push_valid,
   input  logic [DATA_W-1:0]        push_pc,
   input  logic [IMM_W-1:0]         push_imm,
   input  logic                     pop_valid,
   input  logic                     pop_taken,
   output logic [DATA_W-1:0]        head_target,
   output logic [DATA_W-1:0]        redirect_pc,
   output logic                     redirect_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic [15:0]              drop_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] target_q [DEPTH];
   logic [DATA_W-1:0] fall_q   [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
   logic              redirect_valid_q, redirect_valid_d;

   logic              push_c;
   logic              pop_c;
   logic [DATA_W-1:0] imm_sext_c;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   assign pop_c  = pop_valid && !stall && !flush && !empty;
   assign push_c = push_valid && !stall && !flush && (!full || pop_c);

   assign imm_sext_c = DATA_W'($signed(push_imm));

   // Next-state: flush clears occupancy but leaves the last redirect_pc visible.
   always_comb begin
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      count_d          = count_q;
      redirect_pc_d    = redirect_pc_q;
      redirect_valid_d = 1'b0;

      if (pop_c) begin
         rd_ptr_d         = rd_ptr_q + PTR_W'(1);
         redirect_pc_d    = pop_taken ? target_q[rd_ptr_q] : fall_q[rd_ptr_q];
         redirect_valid_d = 1'b1;
      end
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         redirect_pc_q    <= '0;
         redirect_valid_q <= 1'b0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         redirect_pc_q    <= redirect_pc_d;
         redirect_valid_q <= redirect_valid_d;
      end
   end

   // Entry storage is not reset; reads are masked while empty.
   always_ff @(posedge clk) begin
      if (!rst && push_c) begin
         target_q[wr_ptr_q] <= push_pc + imm_sext_c;
         fall_q[wr_ptr_q]   <= push_pc + DATA_W'(4);
      end
   end

   assign head_target    = empty ? '0 : target_q[rd_ptr_q];
   assign redirect_pc    = redirect_pc_q;
   assign redirect_valid = redirect_valid_q;
   assign count          = count_q;

`ifdef BTQ_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        drop_c;

   assign drop_c = push_valid && !stall && !flush && full && !pop_c;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_target_queue.sv
// Bench for branch_target_queue: directed vector table, hand sequences, then random vs a queue model.
module tb_branch_target_queue;

   localparam int unsigned DEPTH = 4;
`ifdef BTQ_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, stall, flush, push_valid, pop_valid, pop_taken;
   logic [31:0] push_pc;
   logic [20:0] push_imm;
   logic [31:0] head_target, redirect_pc;
   logic        redirect_valid, full, empty;
   logic [2:0]  count;
   logic [15:0] drop_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference model
   logic [31:0] mt[$];
   logic [31:0] mf[$];
   logic [31:0] m_rp;
   logic        m_rv;
   int          m_drop;

   always #5 clk = ~clk;

   branch_target_queue #(.DATA_W(32), .DEPTH(DEPTH), .IMM_W(21)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .push_valid(push_valid), .push_pc(push_pc), .push_imm(push_imm),
      .pop_valid(pop_valid), .pop_taken(pop_taken),
      .head_target(head_target), .redirect_pc(redirect_pc),
      .redirect_valid(redirect_valid), .count(count),
      .full(full), .empty(empty), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle, advance the model, sample #1 after the edge.
   task automatic step(input logic r, input logic st, input logic fl, input logic pv,
                       input logic [31:0] pc, input logic [20:0] imm,
                       input logic popv, input logic tk);
      bit do_pop, do_push;
      logic [31:0] sext;
      rst = r; stall = st; flush = fl; push_valid = pv; push_pc = pc;
      push_imm = imm; pop_valid = popv; pop_taken = tk;
      sext = {{11{imm[20]}}, imm};
      if (r) begin
         mt.delete(); mf.delete(); m_rp = '0; m_rv = 1'b0; m_drop = 0;
      end else begin
         do_pop  = popv && !st && !fl && (mt.size() > 0);
         do_push = pv && !st && !fl && ((mt.size() < DEPTH) || do_pop);
         m_rv = 1'b0;
         if (fl) begin
            mt.delete(); mf.delete();
         end
         if (do_pop) begin
            m_rp = tk ? mt[0] : mf[0];
            m_rv = 1'b1;
            void'(mt.pop_front());
            void'(mf.pop_front());
         end
         if (do_push) begin
            mt.push_back(pc + sext);
            mf.push_back(pc + 32'd4);
         end else if (pv && !st && !fl && DROP_EN && m_drop < 65535) begin
            m_drop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      chk("count", 32'(count), 32'(mt.size()));
      chk("full", 32'(full), 32'(mt.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mt.size() == 0));
      chk("head_target", head_target, (mt.size() > 0) ? mt[0] : 32'h0);
      chk("redirect_pc", redirect_pc, m_rp);
      chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
   endtask

   typedef struct {
      logic        st, fl, pv;
      logic [31:0] pc;
      logic [20:0] imm;
      logic        popv, tk;
      int          ecount;
      logic        erv;
      logic [31:0] erp, ehead;
   } vec_t;

   vec_t tbl[24];

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
      pop_taken = 1'b0; push_pc = '0; push_imm = '0;

      //                st    fl    pv    pc          imm         popv  tk    cnt rv    rp          head
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h100,  21'h20,     1'b0, 1'b0, 1, 1'b0, 32'h0,    32'h120};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b1, 0, 1'b1, 32'h120,  32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b0, 1'b0, 0, 1'b0, 32'h120,  32'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h200,  21'h1FFFF8, 1'b0, 1'b0, 1, 1'b0, 32'h120,  32'h1F8};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b0, 0, 1'b1, 32'h204,  32'h0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h1000, 21'h10,     1'b0, 1'b0, 1, 1'b0, 32'h204,  32'h1010};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h2000, 21'h10,     1'b0, 1'b0, 2, 1'b0, 32'h204,  32'h1010};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h3000, 21'h10,     1'b0, 1'b0, 3, 1'b0, 32'h204,  32'h1010};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h4000, 21'h10,     1'b0, 1'b0, 4, 1'b0, 32'h204,  32'h1010};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h5000, 21'h10,     1'b0, 1'b0, 4, 1'b0, 32'h204,  32'h1010};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h6000, 21'h4,      1'b1, 1'b1, 4, 1'b1, 32'h1010, 32'h2010};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b1, 3, 1'b1, 32'h2010, 32'h3010};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b1, 2, 1'b1, 32'h3010, 32'h4010};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b0, 1, 1'b1, 32'h4004, 32'h6004};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b1, 0, 1'b1, 32'h6004, 32'h0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b0, 1'b0, 0, 1'b0, 32'h6004, 32'h0};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h7000, 21'h8,      1'b1, 1'b1, 1, 1'b0, 32'h6004, 32'h7008};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 32'h8000, 21'h8,      1'b0, 1'b0, 2, 1'b0, 32'h6004, 32'h7008};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 32'h9000, 21'h8,      1'b0, 1'b0, 3, 1'b0, 32'h6004, 32'h7008};
      tbl[19] = '{1'b1, 1'b0, 1'b1, 32'hA000, 21'h8,      1'b1, 1'b1, 3, 1'b0, 32'h6004, 32'h7008};
      tbl[20] = '{1'b1, 1'b0, 1'b1, 32'hA000, 21'h8,      1'b1, 1'b1, 3, 1'b0, 32'h6004, 32'h7008};
      tbl[21] = '{1'b1, 1'b0, 1'b1, 32'hA000, 21'h8,      1'b1, 1'b1, 3, 1'b0, 32'h6004, 32'h7008};
      tbl[22] = '{1'b1, 1'b1, 1'b1, 32'hA000, 21'h8,      1'b1, 1'b1, 0, 1'b0, 32'h6004, 32'h0};
      tbl[23] = '{1'b0, 1'b0, 1'b0, 32'h0,    21'h0,      1'b1, 1'b1, 0, 1'b0, 32'h6004, 32'h0};

      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 21'h0, 1'b0, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_head_target", head_target, 32'h0);

      // Directed vector table
      for (int i = 0; i < 24; i++) begin
         step(1'b0, tbl[i].st, tbl[i].fl, tbl[i].pv, tbl[i].pc, tbl[i].imm, tbl[i].popv, tbl[i].tk);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecount));
         chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].ecount == DEPTH));
         chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].ecount == 0));
         chk($sformatf("tbl%0d_rv", i), 32'(redirect_valid), 32'(tbl[i].erv));
         chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].erp);
         chk($sformatf("tbl%0d_head", i), head_target, tbl[i].ehead);
         chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), (DROP_EN && i >= 9) ? 32'd1 : 32'd0);
      end

      // Reset mid-operation overrides flush/push/pop
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 21'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hB000, 21'h40, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000, 21'h40, 1'b1, 1'b1);
      check_model();
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'hD000, 21'h40, 1'b1, 1'b1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_redirect_pc", redirect_pc, 32'h0);
      chk("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("midrst_head", head_target, 32'h0);

      // Overflow drops accumulate across several cycles
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10000 + 32'(i) * 32'h100, 21'h1FFF00, 1'b0, 1'b0);
         check_model();
      end
      chk("drop_three", 32'(drop_cnt), DROP_EN ? 32'd3 : 32'd0);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         logic [20:0] imm;
         imm = 21'($urandom) & ~21'h1;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0),
              $urandom, imm, ($urandom_range(0, 2) != 0), 1'($urandom));
         check_model();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
